// File: rtl/ttl_memory_cell.sv
// Single key/value cache slot with a valid flag, a countdown TTL and a combinational key match.
// Latency: write/delete/expiry visible one cycle after the strobe edge; hit_out is combinational.
// Backpressure: none; strobes are always accepted. Optional macro TTL_MEMORY_CELL_REFRESH_EN adds touch_op.
module ttl_memory_cell #(
  parameter int KEY_WIDTH   = 8,
  parameter int VALUE_WIDTH = 64,
  parameter int TTL_WIDTH   = 32,
  parameter int TICK_DIV    = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write_op,
  input  logic                   delete_op,
`ifdef TTL_MEMORY_CELL_REFRESH_EN
  input  logic                   touch_op,
`endif
  input  logic [KEY_WIDTH-1:0]   key_in,
  input  logic [VALUE_WIDTH-1:0] value_in,
  input  logic [TTL_WIDTH-1:0]   ttl_in,
  input  logic [KEY_WIDTH-1:0]   lookup_key,
  output logic [KEY_WIDTH-1:0]   key_out,
  output logic [VALUE_WIDTH-1:0] value_out,
  output logic [TTL_WIDTH-1:0]   ttl_out,
  output logic                   used_out,
  output logic                   hit_out,
  output logic                   expired_pulse
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    FREE          = 2'd0,
    VALID_TTL     = 2'd1,
    VALID_PERSIST = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic [TTL_WIDTH-1:0]   ttl_q, ttl_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic                   pulse_q, pulse_d;
  logic                   tick;
  logic                   do_touch;
  logic [TTL_WIDTH-1:0]   reload_val;

`ifdef TTL_MEMORY_CELL_REFRESH_EN
  logic [TTL_WIDTH-1:0]   reload_q, reload_d;

  // Lifetime captured at write time, restored by touch_op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) reload_q <= '0;
    else     reload_q <= reload_d;
  end

  assign reload_d   = write_op ? ttl_in : reload_q;
  assign do_touch   = touch_op;
  assign reload_val = reload_q;
`else
  assign do_touch   = 1'b0;
  assign reload_val = '0;
`endif

  assign tick = (state_q == VALID_TTL) && (presc_q == PRESC_MAX);

  // State and datapath registers; reset aborts any countdown without a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FREE;
      key_q   <= '0;
      value_q <= '0;
      ttl_q   <= '0;
      presc_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      value_q <= value_d;
      ttl_q   <= ttl_d;
      presc_q <= presc_d;
      pulse_q <= pulse_d;
    end
  end

  // Next state: write beats delete beats touch beats the expiry tick.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    value_d = value_q;
    ttl_d   = ttl_q;
    presc_d = presc_q;
    pulse_d = 1'b0;
    if (write_op) begin
      key_d   = key_in;
      value_d = value_in;
      presc_d = '0;
      ttl_d   = ttl_in;
      state_d = (ttl_in != '0) ? VALID_TTL : VALID_PERSIST;
    end else if (delete_op) begin
      state_d = FREE;
      key_d   = '0;
      value_d = '0;
      ttl_d   = '0;
      presc_d = '0;
    end else if (do_touch && state_q == VALID_TTL) begin
      ttl_d   = reload_val;
      presc_d = '0;
    end else if (state_q == VALID_TTL) begin
      if (tick) begin
        presc_d = '0;
        if (ttl_q > TTL_WIDTH'(1)) begin
          ttl_d = ttl_q - TTL_WIDTH'(1);
        end else begin
          // Final tick: free the slot and report the expiry once.
          state_d = FREE;
          key_d   = '0;
          value_d = '0;
          ttl_d   = '0;
          pulse_d = 1'b1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  assign key_out       = key_q;
  assign value_out     = value_q;
  assign ttl_out       = ttl_q;
  assign used_out      = (state_q != FREE);
  assign hit_out       = used_out && (key_q == lookup_key);
  assign expired_pulse = pulse_q;

endmodule

// File: tb/tb_ttl_memory_cell.sv
module tb_ttl_memory_cell;

  localparam int KW = 8;
  localparam int VW = 64;
  localparam int TW = 32;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write_op = 1'b0;
  logic          delete_op = 1'b0;
  logic          touch_op = 1'b0;
  logic [KW-1:0] key_in = '0;
  logic [VW-1:0] value_in = '0;
  logic [TW-1:0] ttl_in = '0;
  logic [KW-1:0] lookup_key = '0;
  logic [KW-1:0] key_out;
  logic [VW-1:0] value_out;
  logic [TW-1:0] ttl_out;
  logic          used_out, hit_out, expired_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  ttl_memory_cell #(
    .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TTL_WIDTH(TW), .TICK_DIV(TD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .write_op(write_op),
    .delete_op(delete_op),
`ifdef TTL_MEMORY_CELL_REFRESH_EN
    .touch_op(touch_op),
`endif
    .key_in(key_in),
    .value_in(value_in),
    .ttl_in(ttl_in),
    .lookup_key(lookup_key),
    .key_out(key_out),
    .value_out(value_out),
    .ttl_out(ttl_out),
    .used_out(used_out),
    .hit_out(hit_out),
    .expired_pulse(expired_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an entry loaded with N ticks at elapsed cycle 0 dies once
  // elapsed reaches N*TD; remaining ticks are N - elapsed/TD.
  bit          m_used, m_persist, m_pulse;
  logic [KW-1:0] m_key;
  logic [VW-1:0] m_val;
  int          m_load, m_elapsed;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_used = 0; m_persist = 0; m_pulse = 0;
      m_key = '0; m_val = '0; m_load = 0; m_elapsed = 0;
    end else begin
      m_pulse = 0;
      if (write_op) begin
        m_used = 1; m_key = key_in; m_val = value_in;
        m_persist = (ttl_in == 0); m_load = int'(ttl_in); m_elapsed = 0;
      end else if (delete_op) begin
        m_used = 0; m_persist = 0; m_key = '0; m_val = '0;
`ifdef TTL_MEMORY_CELL_REFRESH_EN
      end else if (touch_op && m_used && !m_persist) begin
        m_elapsed = 0;
`endif
      end else if (m_used && !m_persist) begin
        m_elapsed++;
        if (m_elapsed == m_load * TD) begin
          m_used = 0; m_key = '0; m_val = '0; m_pulse = 1;
        end
      end
    end
  end

  function automatic logic [63:0] m_ttl();
    return (m_used && !m_persist) ? 64'(m_load - m_elapsed / TD) : 64'd0;
  endfunction

  // Every cycle, check all outputs against the model away from the active edge.
  always @(negedge clk) begin
    chk("cyc_used", 64'(used_out), 64'(m_used));
    chk("cyc_key", 64'(key_out), 64'(m_key));
    chk("cyc_value", value_out, m_val);
    chk("cyc_ttl", 64'(ttl_out), m_ttl());
    chk("cyc_hit", 64'(hit_out), 64'(m_used && (m_key == lookup_key)));
    chk("cyc_pulse", 64'(expired_pulse), 64'(m_pulse));
  end

  task automatic nxt(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic do_write(input logic [KW-1:0] k, input logic [VW-1:0] v, input logic [TW-1:0] t);
    write_op = 1'b1; key_in = k; value_in = v; ttl_in = t;
    nxt(1);
    write_op = 1'b0;
  endtask

  task automatic do_delete();
    delete_op = 1'b1;
    nxt(1);
    delete_op = 1'b0;
  endtask

  initial begin
    nxt(2);
    chk("rst_used", 64'(used_out), 64'd0);
    chk("rst_key", 64'(key_out), 64'd0);
    chk("rst_ttl", 64'(ttl_out), 64'd0);
    chk("rst_pulse", 64'(expired_pulse), 64'd0);
    rst = 1'b0;
    nxt(1);

    // Countdown to expiry with TTL=3, TD=4.
    do_write(8'h2A, 64'hDEADBEEF, 32'd3);
    chk("t1_ttl_e0", 64'(ttl_out), 64'd3);
    nxt(4);
    chk("t1_ttl_e4", 64'(ttl_out), 64'd2);
    nxt(4);
    chk("t1_ttl_e8", 64'(ttl_out), 64'd1);
    chk("t1_used_e8", 64'(used_out), 64'd1);
    nxt(3);
    chk("t1_used_e11", 64'(used_out), 64'd1);
    nxt(1);
    chk("t1_used_e12", 64'(used_out), 64'd0);
    chk("t1_pulse_e12", 64'(expired_pulse), 64'd1);
    chk("t1_key_e12", 64'(key_out), 64'd0);
    nxt(1);
    chk("t1_pulse_e13", 64'(expired_pulse), 64'd0);

    // Persistent entry.
    do_write(8'h05, 64'h1234, 32'd0);
    nxt(100);
    chk("t2_used", 64'(used_out), 64'd1);
    chk("t2_ttl", 64'(ttl_out), 64'd0);
    lookup_key = 8'h05; #1;
    chk("t2_hit5", 64'(hit_out), 64'd1);
    lookup_key = 8'h06; #1;
    chk("t2_hit6", 64'(hit_out), 64'd0);
    do_delete();

    // Delete before expiry, then delete while free.
    do_write(8'h33, 64'h55, 32'd2);
    nxt(4);
    chk("t3_ttl_e4", 64'(ttl_out), 64'd1);
    do_delete();
    chk("t3_used", 64'(used_out), 64'd0);
    chk("t3_pulse", 64'(expired_pulse), 64'd0);
    nxt(10);
    do_delete();
    chk("t3_free_used", 64'(used_out), 64'd0);
    chk("t3_free_key", 64'(key_out), 64'd0);

    // Write coinciding with the final tick wins.
    do_write(8'h44, 64'h66, 32'd1);
    nxt(3);
    do_write(8'h11, 64'h77, 32'd5);
    chk("t4_used", 64'(used_out), 64'd1);
    chk("t4_key", 64'(key_out), 64'h11);
    chk("t4_ttl", 64'(ttl_out), 64'd5);
    chk("t4_pulse", 64'(expired_pulse), 64'd0);
    do_delete();

    // Asynchronous reset mid-countdown.
    do_write(8'h55, 64'h99, 32'd10);
    nxt(6);
    rst = 1'b1; #1;
    chk("t5_used", 64'(used_out), 64'd0);
    chk("t5_key", 64'(key_out), 64'd0);
    chk("t5_value", value_out, 64'd0);
    chk("t5_ttl", 64'(ttl_out), 64'd0);
    chk("t5_pulse", 64'(expired_pulse), 64'd0);
    nxt(2);
    rst = 1'b0;
    nxt(60);
    chk("t5_after_used", 64'(used_out), 64'd0);

`ifdef TTL_MEMORY_CELL_REFRESH_EN
    // Touch reloads the TTL and restarts the prescaler.
    do_write(8'h66, 64'hAB, 32'd2);
    nxt(6);
    touch_op = 1'b1;
    nxt(1);
    touch_op = 1'b0;
    chk("t6_ttl_e7", 64'(ttl_out), 64'd2);
    nxt(1);
    chk("t6_used_e8", 64'(used_out), 64'd1);
    nxt(6);
    chk("t6_ttl_e14", 64'(ttl_out), 64'd1);
    nxt(1);
    chk("t6_used_e15", 64'(used_out), 64'd0);
    chk("t6_pulse_e15", 64'(expired_pulse), 64'd1);
`endif

    nxt(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
